// File: rtl/ones_acc_pkg.sv
// Shared types and constants for the ones-count frame accumulator.
package ones_acc_pkg;

    typedef enum logic {ACCUM, HOLD} acc_state_t;

    localparam int COUNT_W   = 4;
    localparam int COUNT_MAX = 15;

endpackage

// File: rtl/ones_count_accumulator_sat_adder.sv
// ones_sat_adder: adds a 4-bit ones count into the frame accumulator.
// Saturates at 2^SUM_W-1 when ONES_ACC_SAT_EN is defined, otherwise wraps.
module ones_sat_adder
    import ones_acc_pkg::*;
#(
    parameter int SUM_W = 8
) (
    input  logic [SUM_W-1:0]   acc,
    input  logic [COUNT_W-1:0] in_count,
    output logic [SUM_W-1:0]   sum,
    output logic               ovf
);

    logic [SUM_W:0] raw;

    assign raw = {1'b0, acc} + {{(SUM_W + 1 - COUNT_W){1'b0}}, in_count};
    assign ovf = raw[SUM_W];

`ifdef ONES_ACC_SAT_EN
    assign sum = ovf ? '1 : raw[SUM_W-1:0];
`else
    assign sum = raw[SUM_W-1:0];
`endif

endmodule

// File: rtl/ones_count_accumulator.sv
// Frame accumulator: sums and peak-tracks FRAME_LEN ones counts, then holds the
// result on a valid/ready port. Optional saturation: ONES_ACC_SAT_EN.
module ones_count_accumulator
    import ones_acc_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int SUM_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [COUNT_W-1:0] in_count,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SUM_W-1:0]   out_sum,
    output logic [COUNT_W-1:0] out_max,
    output logic               out_sat
);

    localparam int              IDX_W    = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    acc_state_t         state, state_nxt;
    logic [SUM_W-1:0]   acc, add_sum;
    logic [COUNT_W-1:0] mx, mx_nxt;
    logic [IDX_W-1:0]   idx;
    logic               add_ovf;
    logic               accept, last;

    ones_sat_adder #(.SUM_W(SUM_W)) u_adder (
        .acc      (acc),
        .in_count (in_count),
        .sum      (add_sum),
        .ovf      (add_ovf)
    );

    // clear wins over a sample offered in the same cycle
    assign accept = (state == ACCUM) && in_valid && !clear;
    assign last   = accept && (idx == LAST_IDX);
    assign mx_nxt = (mx == COUNT_W'(COUNT_MAX) || in_count <= mx) ? mx : in_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (last) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACCUM;
            end
        endcase
    end

`ifdef ONES_ACC_SAT_EN
    logic sat_flag;
`else
    // overflow is irrelevant when the accumulator wraps
    logic unused_ovf;
    assign unused_ovf = add_ovf;
    assign out_sat    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            acc     <= '0;
            mx      <= '0;
            idx     <= '0;
            out_sum <= '0;
            out_max <= '0;
`ifdef ONES_ACC_SAT_EN
            sat_flag <= 1'b0;
            out_sat  <= 1'b0;
`endif
        end else if (state == ACCUM && clear) begin
            acc <= '0;
            mx  <= '0;
            idx <= '0;
`ifdef ONES_ACC_SAT_EN
            sat_flag <= 1'b0;
`endif
        end else if (last) begin
            out_sum <= add_sum;
            out_max <= mx_nxt;
            acc     <= '0;
            mx      <= '0;
            idx     <= '0;
`ifdef ONES_ACC_SAT_EN
            out_sat  <= sat_flag | add_ovf;
            sat_flag <= 1'b0;
`endif
        end else if (accept) begin
            acc <= add_sum;
            mx  <= mx_nxt;
            idx <= idx + 1'b1;
`ifdef ONES_ACC_SAT_EN
            sat_flag <= sat_flag | add_ovf;
`endif
        end
    end

endmodule

// File: tb/tb_ones_count_accumulator.sv
// Scoreboard bench for ones_count_accumulator: three instances cover
// FRAME_LEN=4/SUM_W=8, FRAME_LEN=8/SUM_W=6 and FRAME_LEN=2/SUM_W=8.
module tb_ones_count_accumulator;

    typedef struct packed {
        logic [7:0] sum;
        logic [3:0] mx;
        logic       sat;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] clear, in_valid, out_ready;
    logic [3:0] in_count [3];
    wire  [2:0] in_ready, out_valid, out_sat;
    wire  [7:0] sum0, sum2;
    wire  [5:0] sum1;
    wire  [3:0] max0, max1, max2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    res_t q0[$], q1[$], q2[$];
    int   m_acc [3];
    int   m_mx  [3];
    int   m_idx [3];
    bit   m_sat [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ones_count_accumulator #(.FRAME_LEN(4), .SUM_W(8)) dut0 (
        .clk(clk), .rst(rst), .clear(clear[0]), .in_valid(in_valid[0]), .in_count(in_count[0]),
        .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum0), .out_max(max0), .out_sat(out_sat[0]));

    ones_count_accumulator #(.FRAME_LEN(8), .SUM_W(6)) dut1 (
        .clk(clk), .rst(rst), .clear(clear[1]), .in_valid(in_valid[1]), .in_count(in_count[1]),
        .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum1), .out_max(max1), .out_sat(out_sat[1]));

    ones_count_accumulator #(.FRAME_LEN(2), .SUM_W(8)) dut2 (
        .clk(clk), .rst(rst), .clear(clear[2]), .in_valid(in_valid[2]), .in_count(in_count[2]),
        .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(sum2), .out_max(max2), .out_sat(out_sat[2]));

    function automatic int frame_len(input int i);
        case (i)
            0:       return 4;
            1:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic int sum_max(input int i);
        return (i == 1) ? 63 : 255;
    endfunction

    function automatic res_t observed(input int i);
        case (i)
            0:       return '{sum: sum0, mx: max0, sat: out_sat[0]};
            1:       return '{sum: {2'b00, sum1}, mx: max1, sat: out_sat[1]};
            default: return '{sum: sum2, mx: max2, sat: out_sat[2]};
        endcase
    endfunction

    function automatic void push_exp(input int i, input res_t r);
        case (i)
            0:       q0.push_back(r);
            1:       q1.push_back(r);
            default: q2.push_back(r);
        endcase
    endfunction

    function automatic int queue_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic bit pop_exp(input int i, output res_t r);
        r = '0;
        if (queue_size(i) == 0) return 1'b0;
        case (i)
            0:       r = q0.pop_front();
            1:       r = q1.pop_front();
            default: r = q2.pop_front();
        endcase
        return 1'b1;
    endfunction

    function automatic void model_reset(input int i);
        m_acc[i] = 0;
        m_mx[i]  = 0;
        m_idx[i] = 0;
        m_sat[i] = 1'b0;
    endfunction

    // reference model: called once per sample the bench expects to be accepted
    function automatic void model_accept(input int i, input int v);
        res_t r;
        m_acc[i] = m_acc[i] + v;
        if (m_acc[i] > sum_max(i)) begin
`ifdef ONES_ACC_SAT_EN
            m_acc[i] = sum_max(i);
            m_sat[i] = 1'b1;
`else
            m_acc[i] = m_acc[i] - (sum_max(i) + 1);
`endif
        end
        if (v > m_mx[i]) m_mx[i] = v;
        m_idx[i] = m_idx[i] + 1;
        if (m_idx[i] == frame_len(i)) begin
            r.sum = 8'(m_acc[i]);
            r.mx  = 4'(m_mx[i]);
            r.sat = m_sat[i];
            push_exp(i, r);
            model_reset(i);
        end
    endfunction

    // output monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin : monitor
        res_t e, o;
        for (int i = 0; i < 3; i++) begin
            if (!rst && out_valid[i] && out_ready[i]) begin
                o = observed(i);
                total++;
                if (!pop_exp(i, e)) begin
                    bad++;
                    $display("FAIL result%0d_unexpected got sum=%0d max=%0d sat=%0d, none expected",
                             i, o.sum, o.mx, o.sat);
                end else if (o !== e) begin
                    bad++;
                    $display("FAIL result%0d got sum=%0d max=%0d sat=%0d want sum=%0d max=%0d sat=%0d",
                             i, o.sum, o.mx, o.sat, e.sum, e.mx, e.sat);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // offer one sample; returns the cycle stamp of the accepting edge
    task automatic send(input int i, input int v, output int acc_cyc);
        bit rdy;
        acc_cyc     = -1;
        in_valid[i] = 1'b1;
        in_count[i] = 4'(v);
        for (int n = 0; n < 50; n++) begin
            rdy = in_ready[i];
            @(posedge clk);
            #1;
            if (rdy) begin
                model_accept(i, v);
                acc_cyc = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL send%0d_timeout got in_ready=0 for 50 cycles want 1", i);
    endtask

    task automatic test_reset();
        tick(1);
        total++;
        if (in_ready !== 3'b111 || out_valid !== 3'b000) begin
            bad++;
            $display("FAIL reset_handshake got in_ready=%b out_valid=%b want 111 000", in_ready, out_valid);
        end
        total++;
        if (sum0 !== 8'd0 || sum1 !== 6'd0 || sum2 !== 8'd0 || max0 !== 4'd0 || max1 !== 4'd0 ||
            max2 !== 4'd0 || out_sat !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs got sums=%0d/%0d/%0d maxes=%0d/%0d/%0d sat=%b want all 0",
                     sum0, sum1, sum2, max0, max1, max2, out_sat);
        end
    endtask

    task automatic test_basic();
        int c;
        out_ready[0] = 1'b1;
        send(0, 3, c);
        send(0, 15, c);
        send(0, 0, c);
        send(0, 7, c);
        in_valid[0] = 1'b0;
        total++;
        if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL basic_latency got out_valid=%b in_ready=%b want 1 0", out_valid[0], in_ready[0]);
        end
        total++;
        if (sum0 !== 8'd25 || max0 !== 4'd15 || out_sat[0] !== 1'b0) begin
            bad++;
            $display("FAIL basic_result got sum=%0d max=%0d sat=%b want 25 15 0", sum0, max0, out_sat[0]);
        end
        tick(1);
        total++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL basic_release got out_valid=%b in_ready=%b want 0 1", out_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_gaps_backpressure();
        int c;
        out_ready[0] = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            send(0, v, c);
            in_valid[0] = 1'b0;
            if (v < 4) tick(2);
        end
        for (int n = 0; n < 5; n++) begin
            total++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || sum0 !== 8'd10 || max0 !== 4'd4) begin
                bad++;
                $display("FAIL hold_frozen cycle %0d got valid=%b ready=%b sum=%0d max=%0d want 1 0 10 4",
                         n, out_valid[0], in_ready[0], sum0, max0);
            end
            tick(1);
        end
        out_ready[0] = 1'b1;
        tick(1);
        total++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL hold_release got in_ready=%b out_valid=%b want 1 0", in_ready[0], out_valid[0]);
        end
    endtask

    task automatic test_overflow();
        int   c;
        logic [5:0] want_sum;
        logic       want_sat;
`ifdef ONES_ACC_SAT_EN
        want_sum = 6'd63;
        want_sat = 1'b1;
`else
        want_sum = 6'd56;
        want_sat = 1'b0;
`endif
        out_ready[1] = 1'b1;
        for (int n = 0; n < 8; n++) send(1, 15, c);
        in_valid[1] = 1'b0;
        total++;
        if (out_valid[1] !== 1'b1 || sum1 !== want_sum || out_sat[1] !== want_sat || max1 !== 4'd15) begin
            bad++;
            $display("FAIL overflow got valid=%b sum=%0d sat=%b max=%0d want 1 %0d %b 15",
                     out_valid[1], sum1, out_sat[1], max1, want_sum, want_sat);
        end
        tick(1);
    endtask

    task automatic test_clear();
        int c;
        out_ready[0] = 1'b1;
        send(0, 9, c);
        send(0, 9, c);
        in_valid[0] = 1'b1;
        in_count[0] = 4'd9;
        clear[0]    = 1'b1;
        tick(1);
        clear[0]    = 1'b0;
        in_valid[0] = 1'b0;
        model_reset(0);
        total++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL clear_state got in_ready=%b out_valid=%b want 1 0", in_ready[0], out_valid[0]);
        end
        for (int v = 1; v <= 4; v++) send(0, v, c);
        in_valid[0] = 1'b0;
        total++;
        if (sum0 !== 8'd10 || max0 !== 4'd4) begin
            bad++;
            $display("FAIL clear_result got sum=%0d max=%0d want 10 4", sum0, max0);
        end
        tick(1);
    endtask

    task automatic test_async_reset();
        int c;
        out_ready[0] = 1'b1;
        send(0, 5, c);
        send(0, 5, c);
        in_valid[0] = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || sum0 !== 8'd0 || max0 !== 4'd0) begin
            bad++;
            $display("FAIL async_rst_accum got ready=%b valid=%b sum=%0d max=%0d want 1 0 0 0",
                     in_ready[0], out_valid[0], sum0, max0);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) model_reset(i);
        tick(1);
        for (int n = 0; n < 4; n++) send(0, 6, c);
        in_valid[0] = 1'b0;
        tick(1);

        out_ready[0] = 1'b0;
        for (int n = 0; n < 4; n++) send(0, 1, c);
        in_valid[0] = 1'b0;
        total++;
        if (out_valid[0] !== 1'b1) begin
            bad++;
            $display("FAIL async_rst_prehold got out_valid=%b want 1", out_valid[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL async_rst_hold got out_valid=%b in_ready=%b want 0 1", out_valid[0], in_ready[0]);
        end
        q0.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) model_reset(i);
        out_ready[0] = 1'b1;
        tick(1);
    endtask

    task automatic test_back_to_back();
        int c, c_last1, c_first2;
        out_ready[2] = 1'b1;
        send(2, 15, c);
        send(2, 15, c_last1);
        send(2, 1, c_first2);
        send(2, 2, c);
        in_valid[2] = 1'b0;
        total++;
        if (c_first2 - c_last1 !== 2) begin
            bad++;
            $display("FAIL b2b_gap got %0d cycles between frames want 2", c_first2 - c_last1);
        end
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        clear     = '0;
        in_valid  = '0;
        out_ready = '1;
        for (int i = 0; i < 3; i++) begin
            in_count[i] = '0;
            model_reset(i);
        end
        #12;
        rst = 1'b0;

        test_reset();
        test_basic();
        test_gaps_backpressure();
        test_overflow();
        test_clear();
        test_async_reset();
        test_back_to_back();

        total++;
        if (q0.size() + q1.size() + q2.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d/%0d/%0d pending want 0/0/0", q0.size(), q1.size(), q2.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
